// File: rtl/agu_pipe_if.sv
//==============================================================================
// Module   : agu_pipe_if
// Brief    : Request/response bundle between the LSU issue stage and agu_pipe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface agu_pipe_if #(
    parameter int XLEN             = 64,
    parameter int VIRTUAL_ADDR_LEN = 39,
    parameter int TAG_W            = 5
);
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [XLEN-1:0]             req_base_i;
    logic [XLEN-1:0]             req_offset_i;
    logic [1:0]                  req_size_i;
    logic                        req_is_store_i;
    logic [TAG_W-1:0]            req_tag_i;

    logic                        resp_valid_o;
    logic                        resp_ready_i;
    logic [VIRTUAL_ADDR_LEN-1:0] resp_addr_o;
    logic [1:0]                  resp_size_o;
    logic                        resp_is_store_o;
    logic [TAG_W-1:0]            resp_tag_o;
    logic                        resp_misalign_o;
    logic                        resp_page_cross_o;
    logic                        resp_noncanon_o;

    // The AGU itself is the slave: it consumes requests and produces responses.
    modport slave (
        input  req_valid_i, req_base_i, req_offset_i, req_size_i,
               req_is_store_i, req_tag_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_addr_o, resp_size_o,
               resp_is_store_o, resp_tag_o, resp_misalign_o,
               resp_page_cross_o, resp_noncanon_o
    );

    modport master (
        output req_valid_i, req_base_i, req_offset_i, req_size_i,
               req_is_store_i, req_tag_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_addr_o, resp_size_o,
               resp_is_store_o, resp_tag_o, resp_misalign_o,
               resp_page_cross_o, resp_noncanon_o
    );
endinterface

`default_nettype wire

// File: rtl/agu_pipe.sv
//==============================================================================
// Module   : agu_pipe
// Brief    : Pipelined address generation unit with a 2-entry skid FIFO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module agu_pipe #(
    parameter int XLEN             = 64,
    parameter int VIRTUAL_ADDR_LEN = 39,
    parameter int TAG_W            = 5,
    parameter int PAGE_OFFSET_W    = 12
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    input  wire logic   flush_i,
    agu_pipe_if.slave   bus
);

    typedef struct packed {
        logic [VIRTUAL_ADDR_LEN-1:0] addr;
        logic [1:0]                  size;
        logic                        is_store;
        logic [TAG_W-1:0]            tag;
        logic                        misalign;
        logic                        page_cross;
        logic                        noncanon;
    } entry_t;

    localparam int c_DEPTH = 2;

    entry_t      mem_q [c_DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    logic                     w_enq;
    logic                     w_deq;
    logic [XLEN-1:0]          w_sum;
    logic [VIRTUAL_ADDR_LEN-1:0] w_addr;
    logic                     w_noncanon;
    logic                     w_misalign;
    logic [PAGE_OFFSET_W:0]   w_span;
    logic [PAGE_OFFSET_W:0]   w_pc_sum;
    entry_t                   w_new;
    entry_t                   w_head;

    // Handshake status depends only on the occupancy register.
    assign bus.req_ready_o  = (count_q != 2'd2);
    assign bus.resp_valid_o = (count_q != 2'd0);

    assign w_enq = bus.req_valid_i && bus.req_ready_o && !flush_i;
    assign w_deq = bus.resp_valid_o && bus.resp_ready_i && !flush_i;

    assign w_sum      = bus.req_base_i + bus.req_offset_i;
    assign w_addr     = w_sum[VIRTUAL_ADDR_LEN-1:0];
    assign w_noncanon = (w_sum[XLEN-1:VIRTUAL_ADDR_LEN] !=
                         {(XLEN-VIRTUAL_ADDR_LEN){w_sum[VIRTUAL_ADDR_LEN-1]}});

    always_comb begin
        w_misalign = 1'b0;
        w_span     = '0;
        case (bus.req_size_i)
            2'd0: begin
                w_misalign = 1'b0;
                w_span     = (PAGE_OFFSET_W+1)'(0);
            end
            2'd1: begin
                w_misalign = w_addr[0];
                w_span     = (PAGE_OFFSET_W+1)'(1);
            end
            2'd2: begin
                w_misalign = |w_addr[1:0];
                w_span     = (PAGE_OFFSET_W+1)'(3);
            end
            default: begin
                w_misalign = |w_addr[2:0];
                w_span     = (PAGE_OFFSET_W+1)'(7);
            end
        endcase
    end

    // The last byte of the access lands in the next page when this carries out.
    assign w_pc_sum = {1'b0, w_addr[PAGE_OFFSET_W-1:0]} + w_span;

    always_comb begin
        w_new            = '0;
        w_new.addr       = w_addr;
        w_new.size       = bus.req_size_i;
        w_new.is_store   = bus.req_is_store_i;
        w_new.tag        = bus.req_tag_i;
        w_new.misalign   = w_misalign;
        w_new.page_cross = w_pc_sum[PAGE_OFFSET_W];
        w_new.noncanon   = w_noncanon;
    end

    always_comb begin
        count_d = count_q;
        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (w_enq) begin
                    mem_q[wr_ptr_q] <= w_new;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (w_deq) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign w_head = mem_q[rd_ptr_q];

    assign bus.resp_addr_o       = w_head.addr;
    assign bus.resp_size_o       = w_head.size;
    assign bus.resp_is_store_o   = w_head.is_store;
    assign bus.resp_tag_o        = w_head.tag;
    assign bus.resp_misalign_o   = w_head.misalign;
    assign bus.resp_page_cross_o = w_head.page_cross;
    assign bus.resp_noncanon_o   = w_head.noncanon;

endmodule

`default_nettype wire
